// File: rtl/riscv_checkpoint_monitor.sv
// Checkpoint monitor for RISCV_TOP: compares (NUM_INST, OUTPUT_PORT) against an
// ascending table of checkpoints and reports pass/fail, failing entry and run cycles.
module riscv_checkpoint_monitor #(
  parameter int NUM_TEST   = 40,
  parameter int IDXW       = 6,
  parameter int MAX_CYCLES = 1000000
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            TBL_WE,
  input  logic [IDXW-1:0] TBL_ADDR,
  input  logic [31:0]     TBL_NINST,
  input  logic [31:0]     TBL_ANS,
  input  logic            START,
  input  logic            CLEAR,
  input  logic [31:0]     NUM_INST,
  input  logic [31:0]     OUTPUT_PORT,
  input  logic            HALT,
  output logic            DONE,
  output logic            PASSED,
  output logic [1:0]      FAIL_CODE,
  output logic [IDXW-1:0] FAIL_IDX,
  output logic [31:0]     FAIL_GOT,
  output logic [IDXW-1:0] PASS_CNT,
  output logic [31:0]     CYCLE
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  localparam logic [1:0]      FC_MISMATCH   = 2'd0;
  localparam logic [1:0]      FC_SKIPPED    = 2'd1;
  localparam logic [1:0]      FC_INCOMPLETE = 2'd2;
  localparam logic [1:0]      FC_TIMEOUT    = 2'd3;
  localparam logic [IDXW-1:0] NUM_TEST_W    = IDXW'(NUM_TEST);
  localparam logic [31:0]     TIMEOUT_AT    = 32'(MAX_CYCLES - 1);
  localparam int              TBL_DEPTH     = 1 << IDXW;

  // Table is sized to the full index space so PASS_CNT can address it directly.
  logic [31:0]     tbl_ninst_r [TBL_DEPTH];
  logic [31:0]     tbl_ans_r   [TBL_DEPTH];

  state_t          state_r;
  logic [IDXW-1:0] pass_cnt_r;
  logic [31:0]     cycle_r;
  logic [1:0]      fail_code_r;
  logic [IDXW-1:0] fail_idx_r;
  logic [31:0]     fail_got_r;
  logic            done_r;
  logic            passed_r;

  logic [31:0]     e_ninst_s;
  logic [31:0]     e_ans_s;
  logic            in_range_s;
  logic            hit_s;
  logic            skip_s;
  logic [IDXW-1:0] cnt_post_s;
  logic [31:0]     cycle_inc_s;
  logic            go_fail_s;
  logic            go_pass_s;
  logic [1:0]      fail_code_s;
  logic [IDXW-1:0] fail_idx_s;
  logic [31:0]     fail_got_s;

  assign e_ninst_s   = tbl_ninst_r[pass_cnt_r];
  assign e_ans_s     = tbl_ans_r[pass_cnt_r];
  assign in_range_s  = (pass_cnt_r < NUM_TEST_W);
  assign hit_s       = in_range_s && (NUM_INST == e_ninst_s);
  assign skip_s      = in_range_s && (NUM_INST > e_ninst_s);
  assign cnt_post_s  = (hit_s && (OUTPUT_PORT == e_ans_s)) ? pass_cnt_r + IDXW'(1) : pass_cnt_r;
  assign cycle_inc_s = (cycle_r == 32'hFFFF_FFFF) ? cycle_r : cycle_r + 32'd1;

  // Table load port, only accepted while idle.
  always_ff @(posedge CLK) begin
    if (TBL_WE && (state_r == ST_IDLE) && !RST) begin
      tbl_ninst_r[TBL_ADDR] <= TBL_NINST;
      tbl_ans_r[TBL_ADDR]   <= TBL_ANS;
    end
  end

  // RUN-state verdict, prioritised mismatch > skipped > halt > timeout.
  always_comb begin
    go_fail_s   = 1'b0;
    go_pass_s   = 1'b0;
    fail_code_s = FC_MISMATCH;
    fail_idx_s  = pass_cnt_r;
    fail_got_s  = OUTPUT_PORT;
    if (hit_s && (OUTPUT_PORT != e_ans_s)) begin
      go_fail_s = 1'b1;
    end else if (skip_s) begin
      go_fail_s   = 1'b1;
      fail_code_s = FC_SKIPPED;
      fail_got_s  = NUM_INST;
    end else if (HALT) begin
      if (cnt_post_s == NUM_TEST_W) begin
        go_pass_s = 1'b1;
      end else begin
        go_fail_s   = 1'b1;
        fail_code_s = FC_INCOMPLETE;
        fail_idx_s  = cnt_post_s;
      end
    end else if (!hit_s && (cycle_r == TIMEOUT_AT)) begin
      go_fail_s   = 1'b1;
      fail_code_s = FC_TIMEOUT;
    end else begin
      go_fail_s = 1'b0;
    end
  end

  // Monitor FSM with registered status outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r     <= ST_IDLE;
      pass_cnt_r  <= '0;
      cycle_r     <= 32'd0;
      fail_code_r <= 2'd0;
      fail_idx_r  <= '0;
      fail_got_r  <= 32'd0;
      done_r      <= 1'b0;
      passed_r    <= 1'b0;
    end else if (CLEAR) begin
      state_r     <= ST_IDLE;
      pass_cnt_r  <= '0;
      cycle_r     <= 32'd0;
      fail_code_r <= 2'd0;
      fail_idx_r  <= '0;
      fail_got_r  <= 32'd0;
      done_r      <= 1'b0;
      passed_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (START) begin
            state_r     <= ST_RUN;
            pass_cnt_r  <= '0;
            cycle_r     <= 32'd0;
            fail_code_r <= 2'd0;
            fail_idx_r  <= '0;
            fail_got_r  <= 32'd0;
            done_r      <= 1'b0;
            passed_r    <= 1'b0;
          end
        end
        ST_RUN: begin
          cycle_r    <= cycle_inc_s;
          pass_cnt_r <= cnt_post_s;
          if (go_fail_s) begin
            state_r     <= ST_FAIL;
            fail_code_r <= fail_code_s;
            fail_idx_r  <= fail_idx_s;
            fail_got_r  <= fail_got_s;
            done_r      <= 1'b1;
          end else if (go_pass_s) begin
            state_r  <= ST_PASS;
            done_r   <= 1'b1;
            passed_r <= 1'b1;
          end
        end
        ST_PASS, ST_FAIL: begin
          state_r <= state_r;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign DONE      = done_r;
  assign PASSED    = passed_r;
  assign FAIL_CODE = fail_code_r;
  assign FAIL_IDX  = fail_idx_r;
  assign FAIL_GOT  = fail_got_r;
  assign PASS_CNT  = pass_cnt_r;
  assign CYCLE     = cycle_r;

endmodule

// File: tb/tb_riscv_checkpoint_monitor.sv
// Directed self-checking bench for riscv_checkpoint_monitor (2-entry table, 16-cycle timeout).
module tb_riscv_checkpoint_monitor;

  localparam int IDXW = 2;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic            TBL_WE = 1'b0;
  logic [IDXW-1:0] TBL_ADDR = '0;
  logic [31:0]     TBL_NINST = 32'd0;
  logic [31:0]     TBL_ANS = 32'd0;
  logic            START = 1'b0;
  logic            CLEAR = 1'b0;
  logic [31:0]     NUM_INST = 32'd0;
  logic [31:0]     OUTPUT_PORT = 32'd0;
  logic            HALT = 1'b0;
  logic            DONE;
  logic            PASSED;
  logic [1:0]      FAIL_CODE;
  logic [IDXW-1:0] FAIL_IDX;
  logic [31:0]     FAIL_GOT;
  logic [IDXW-1:0] PASS_CNT;
  logic [31:0]     CYCLE;

  int n_checks = 0;
  int n_fail   = 0;

  riscv_checkpoint_monitor #(.NUM_TEST(2), .IDXW(IDXW), .MAX_CYCLES(16)) dut (
    .CLK(CLK), .RST(RST), .TBL_WE(TBL_WE), .TBL_ADDR(TBL_ADDR),
    .TBL_NINST(TBL_NINST), .TBL_ANS(TBL_ANS), .START(START), .CLEAR(CLEAR),
    .NUM_INST(NUM_INST), .OUTPUT_PORT(OUTPUT_PORT), .HALT(HALT),
    .DONE(DONE), .PASSED(PASSED), .FAIL_CODE(FAIL_CODE), .FAIL_IDX(FAIL_IDX),
    .FAIL_GOT(FAIL_GOT), .PASS_CNT(PASS_CNT), .CYCLE(CYCLE)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_edge(input logic [31:0] ni, input logic [31:0] op, input logic h);
    NUM_INST = ni; OUTPUT_PORT = op; HALT = h;
    step();
  endtask

  task automatic tbl_write(input logic [IDXW-1:0] a, input logic [31:0] n, input logic [31:0] v);
    TBL_WE = 1'b1; TBL_ADDR = a; TBL_NINST = n; TBL_ANS = v;
    step();
    TBL_WE = 1'b0;
  endtask

  task automatic load_t1();
    tbl_write(2'd0, 32'd4, 32'h0000_0f00);
    tbl_write(2'd1, 32'd6, 32'h0000_0018);
  endtask

  task automatic restart();
    NUM_INST = 32'd0; OUTPUT_PORT = 32'd0; HALT = 1'b0;
    CLEAR = 1'b1; step(); CLEAR = 1'b0;
    START = 1'b1; step(); START = 1'b0;
  endtask

  task automatic run_t1(input string tag);
    run_edge(32'd0, 32'd0, 1'b0);
    run_edge(32'd4, 32'h0f00, 1'b0);
    check_eq({tag, "_cnt1"}, 32'(PASS_CNT), 32'd1);
    run_edge(32'd6, 32'h0018, 1'b0);
    check_eq({tag, "_cnt2"}, 32'(PASS_CNT), 32'd2);
    check_eq({tag, "_done_pre"}, 32'(DONE), 32'd0);
    run_edge(32'd6, 32'h0018, 1'b1);
    check_eq({tag, "_passed"}, 32'(PASSED), 32'd1);
    check_eq({tag, "_done"}, 32'(DONE), 32'd1);
    check_eq({tag, "_cycle"}, CYCLE, 32'd4);
    HALT = 1'b0;
    step();
    check_eq({tag, "_cycle_frozen"}, CYCLE, 32'd4);
    check_eq({tag, "_passed_sticky"}, 32'(PASSED), 32'd1);
  endtask

  initial begin
    // Reset state
    step();
    check_eq("rst_done", 32'(DONE), 32'd0);
    check_eq("rst_passed", 32'(PASSED), 32'd0);
    check_eq("rst_cycle", CYCLE, 32'd0);
    check_eq("rst_cnt", 32'(PASS_CNT), 32'd0);
    RST = 1'b0;
    step();

    // T1: normal pass
    load_t1();
    restart();
    check_eq("t1_start_cycle", CYCLE, 32'd0);
    run_t1("t1");

    // T2: mismatch on entry 1
    restart();
    run_edge(32'd4, 32'h0f00, 1'b0);
    check_eq("t2_done_pre", 32'(DONE), 32'd0);
    run_edge(32'd6, 32'h0019, 1'b0);
    check_eq("t2_done", 32'(DONE), 32'd1);
    check_eq("t2_passed", 32'(PASSED), 32'd0);
    check_eq("t2_code", 32'(FAIL_CODE), 32'd0);
    check_eq("t2_idx", 32'(FAIL_IDX), 32'd1);
    check_eq("t2_got", FAIL_GOT, 32'h19);

    // T3: skipped checkpoint
    restart();
    run_edge(32'd3, 32'd0, 1'b0);
    check_eq("t3_done_pre", 32'(DONE), 32'd0);
    run_edge(32'd5, 32'd0, 1'b0);
    check_eq("t3_code", 32'(FAIL_CODE), 32'd1);
    check_eq("t3_idx", 32'(FAIL_IDX), 32'd0);
    check_eq("t3_got", FAIL_GOT, 32'd5);
    check_eq("t3_done", 32'(DONE), 32'd1);

    // T4a: halt after one checkpoint
    restart();
    run_edge(32'd4, 32'h0f00, 1'b0);
    run_edge(32'd5, 32'h0f00, 1'b1);
    check_eq("t4_code", 32'(FAIL_CODE), 32'd2);
    check_eq("t4_cnt", 32'(PASS_CNT), 32'd1);
    check_eq("t4_done", 32'(DONE), 32'd1);
    check_eq("t4_passed", 32'(PASSED), 32'd0);

    // T4b: final match and halt in the same cycle
    restart();
    run_edge(32'd4, 32'h0f00, 1'b0);
    run_edge(32'd6, 32'h0018, 1'b1);
    check_eq("t4b_passed", 32'(PASSED), 32'd1);
    check_eq("t4b_cnt", 32'(PASS_CNT), 32'd2);
    check_eq("t4b_cycle", CYCLE, 32'd2);

    // T5: timeout after 16 RUN cycles
    restart();
    for (int i = 0; i < 15; i++) run_edge(32'd0, 32'd0, 1'b0);
    check_eq("t5_cycle15", CYCLE, 32'd15);
    check_eq("t5_done_pre", 32'(DONE), 32'd0);
    run_edge(32'd0, 32'd0, 1'b0);
    check_eq("t5_code", 32'(FAIL_CODE), 32'd3);
    check_eq("t5_done", 32'(DONE), 32'd1);
    check_eq("t5_cycle", CYCLE, 32'd16);
    check_eq("t5_idx", 32'(FAIL_IDX), 32'd0);

    // T5b: asynchronous reset while running
    restart();
    run_edge(32'd4, 32'h0f00, 1'b0);
    run_edge(32'd5, 32'd0, 1'b0);
    check_eq("t5b_cnt_pre", 32'(PASS_CNT), 32'd1);
    #2;
    RST = 1'b1;
    #1;
    check_eq("t5b_cnt", 32'(PASS_CNT), 32'd0);
    check_eq("t5b_cycle", CYCLE, 32'd0);
    check_eq("t5b_code", 32'(FAIL_CODE), 32'd0);
    check_eq("t5b_done", 32'(DONE), 32'd0);
    step();
    RST = 1'b0;
    step();

    // T6: table write during RUN is ignored, then CLEAR/START rerun passes
    load_t1();
    restart();
    TBL_WE = 1'b1; TBL_ADDR = 2'd0; TBL_NINST = 32'd100; TBL_ANS = 32'd0;
    run_t1("t6");
    TBL_WE = 1'b0;
    restart();
    run_t1("t6_rerun");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench time limit exceeded");
  end

endmodule
